// File: rtl/btn_arb_pkg.sv
// Shared types and helpers for the button event arbiter.
//   arb_state_t : arbiter FSM encoding (IDLE, OFFER)
//   id_width()  : width of a channel index for n channels (minimum 1 bit)
package btn_arb_pkg;

   typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} arb_state_t;

   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// Single-channel debouncer: counter plus stable-level flop.
// Build option: BTN_ARB_DEBOUNCE_EN. When undefined, the counter is removed
// and the stable level is simply the synced input delayed by one flop.
// Ports:
//   clk, nrst : clock, async active-low reset
//   i_synced  : synchronized raw level
//   o_stable  : debounced level (registered)
//   o_rise    : high on the edge where o_stable will go 0->1
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic nrst,
   input  logic i_synced,
   output logic o_stable,
   output logic o_rise
);

   if (DEBOUNCE_CYCLES < 2) begin : g_bad_cfg
      $error("btn_debounce: DEBOUNCE_CYCLES must be at least 2");
   end

   logic r_stable;

`ifdef BTN_ARB_DEBOUNCE_EN
   localparam int CW = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] C_TC = CW'(DEBOUNCE_CYCLES - 1);

   logic [CW-1:0] r_cnt;
   logic          w_mis;
   logic          w_tc;

   assign w_mis = (i_synced != r_stable);
   assign w_tc  = (r_cnt == C_TC);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_cnt    <= '0;
         r_stable <= 1'b0;
      end else if (w_mis) begin
         if (w_tc) begin
            r_stable <= i_synced;
            r_cnt    <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else begin
         r_cnt <= '0;
      end
   end

   // Rising flip is known one edge early so the press latches with the flip.
   assign o_rise = w_mis & w_tc & i_synced;
`else
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_stable <= 1'b0;
      else       r_stable <= i_synced;
   end

   assign o_rise = i_synced & ~r_stable;
`endif

   assign o_stable = r_stable;

endmodule

// File: rtl/sync.sv
// Shared multi-bit synchronizer: WIDTH flop stages per bit, reset to 0.
// Ports:
//   clk, nrst        : clock, async active-low reset
//   i_data[QUANTITY] : asynchronous inputs
//   o_data[QUANTITY] : synchronized outputs (WIDTH edges of latency)
module sync #(
   parameter int QUANTITY = 1,
   parameter int WIDTH    = 2
) (
   input  logic                clk,
   input  logic                nrst,
   input  logic [QUANTITY-1:0] i_data,
   output logic [QUANTITY-1:0] o_data
);

   logic [QUANTITY-1:0] r_stage [WIDTH];

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         for (int k = 0; k < WIDTH; k++) r_stage[k] <= '0;
      end else begin
         r_stage[0] <= i_data;
         for (int k = 1; k < WIDTH; k++) r_stage[k] <= r_stage[k-1];
      end
   end

   assign o_data = r_stage[WIDTH-1];

endmodule

// File: rtl/btn_event_arb.sv
// Button front end: synchronizes and debounces N_BTN raw inputs, latches
// presses as pending requests and serves them round-robin over valid/ready.
// Build option: BTN_ARB_DEBOUNCE_EN enables the debounce counters.
// Ports:
//   clk, nrst    : clock, async active-low reset
//   btn_raw      : asynchronous raw button levels
//   evt_ready    : consumer accepts the offered event
//   evt_valid    : event offered (registered)
//   evt_id       : channel of the offered event (registered)
//   stable       : debounced levels
//   pending      : latched, undelivered presses
//
// state | meaning
// IDLE  | no event offered; pick next pending channel if any
// OFFER | evt_valid/evt_id held until evt_ready
module btn_event_arb
   import btn_arb_pkg::*;
#(
   parameter int N_BTN           = 4,
   parameter int SYNC_WIDTH      = 2,
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic                            clk,
   input  logic                            nrst,
   input  logic [N_BTN-1:0]                btn_raw,
   input  logic                            evt_ready,
   output logic                            evt_valid,
   output logic [id_width(N_BTN)-1:0]      evt_id,
   output logic [N_BTN-1:0]                stable,
   output logic [N_BTN-1:0]                pending
);

   localparam int IDW = id_width(N_BTN);

   logic [N_BTN-1:0] w_synced;
   logic [N_BTN-1:0] w_stable;
   logic [N_BTN-1:0] w_rise;
   logic [N_BTN-1:0] w_clr;
   logic [IDW-1:0]   w_sel;
   logic [IDW-1:0]   w_idx;
   logic             w_found;
   int               w_pos;

   logic [N_BTN-1:0] r_pending;
   logic [IDW-1:0]   r_evt_id;
   logic [IDW-1:0]   r_last_id;
   logic             r_evt_valid;
   arb_state_t       r_state;

   sync #(
      .QUANTITY (N_BTN),
      .WIDTH    (SYNC_WIDTH)
   ) u_sync (
      .clk    (clk),
      .nrst   (nrst),
      .i_data (btn_raw),
      .o_data (w_synced)
   );

   for (genvar g = 0; g < N_BTN; g++) begin : g_db
      btn_debounce #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
      ) u_db (
         .clk      (clk),
         .nrst     (nrst),
         .i_synced (w_synced[g]),
         .o_stable (w_stable[g]),
         .o_rise   (w_rise[g])
      );
   end

   // First pending channel searching upward from last_id+1, with wrap.
   always_comb begin
      w_sel   = '0;
      w_idx   = '0;
      w_found = 1'b0;
      w_pos   = 0;
      for (int k = 1; k <= N_BTN; k++) begin
         w_pos = (int'(r_last_id) + k) % N_BTN;
         w_idx = IDW'(w_pos);
         if (!w_found && r_pending[w_idx]) begin
            w_sel   = w_idx;
            w_found = 1'b1;
         end
      end
   end

   always_comb begin
      w_clr = '0;
      if (r_state == OFFER && evt_ready) w_clr[r_evt_id] = 1'b1;
   end

   // A press landing on the accept edge survives the clear (set wins).
   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) r_pending <= '0;
      else       r_pending <= (r_pending & ~w_clr) | w_rise;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         r_state     <= IDLE;
         r_evt_valid <= 1'b0;
         r_evt_id    <= '0;
         r_last_id   <= IDW'(N_BTN - 1);
      end else begin
         case (r_state)
            IDLE: begin
               if (|r_pending) begin
                  r_evt_id    <= w_sel;
                  r_evt_valid <= 1'b1;
                  r_state     <= OFFER;
               end
            end
            OFFER: begin
               if (evt_ready) begin
                  r_last_id   <= r_evt_id;
                  r_evt_valid <= 1'b0;
                  r_state     <= IDLE;
               end
            end
            default: begin
               r_evt_valid <= 1'b0;
               r_state     <= IDLE;
            end
         endcase
      end
   end

   assign evt_valid = r_evt_valid;
   assign evt_id    = r_evt_id;
   assign stable    = w_stable;
   assign pending   = r_pending;

endmodule

// File: tb/tb_btn_event_arb.sv
module tb_btn_event_arb;

   localparam int N_BTN = 4;
   localparam int SW    = 2;
   localparam int DC    = 4;
   localparam int GAP   = 4;
`ifdef BTN_ARB_DEBOUNCE_EN
   localparam int LAT = SW + DC;
`else
   localparam int LAT = SW + 1;
`endif

   logic       clk = 1'b0;
   logic       nrst = 1'b0;
   logic       evt_ready = 1'b0;
   logic [3:0] btn_raw = '0;
   logic       evt_valid;
   logic [1:0] evt_id;
   logic [3:0] stable;
   logic [3:0] pending;

   int checks = 0;
   int failures = 0;
   int nev;

   btn_event_arb #(
      .N_BTN           (N_BTN),
      .SYNC_WIDTH      (SW),
      .DEBOUNCE_CYCLES (DC)
   ) dut (
      .clk       (clk),
      .nrst      (nrst),
      .btn_raw   (btn_raw),
      .evt_ready (evt_ready),
      .evt_valid (evt_valid),
      .evt_id    (evt_id),
      .stable    (stable),
      .pending   (pending)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n = 1);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset;
      nrst = 1'b0;
      btn_raw = '0;
      tick(2);
      nrst = 1'b1;
   endtask

   initial begin
      // 1: reset with random raw inputs, then idle
      for (int c = 0; c < 4; c++) begin
         btn_raw = 4'($urandom);
         tick();
         chk("rst_valid", 32'(evt_valid), 0);
         chk("rst_id", 32'(evt_id), 0);
         chk("rst_stable", 32'(stable), 0);
         chk("rst_pending", 32'(pending), 0);
      end
      btn_raw = '0;
      tick();
      nrst = 1'b1;
      for (int c = 0; c < 20; c++) begin
         tick();
         chk("idle_valid", 32'(evt_valid), 0);
      end

      // 2: single press on channel 2, ready held high
      evt_ready = 1'b1;
      btn_raw[2] = 1'b1;
      tick(LAT - 1);
      chk("t2_stable_pre", 32'(stable), 0);
      chk("t2_pending_pre", 32'(pending), 0);
      tick();
      chk("t2_stable", 32'(stable), 4'b0100);
      chk("t2_pending", 32'(pending), 4'b0100);
      chk("t2_valid_pre", 32'(evt_valid), 0);
      tick();
      chk("t2_valid", 32'(evt_valid), 1);
      chk("t2_id", 32'(evt_id), 2);
      tick();
      chk("t2_valid_done", 32'(evt_valid), 0);
      chk("t2_pending_done", 32'(pending), 0);
      btn_raw[2] = 1'b0;
      for (int c = 0; c < LAT + 2; c++) begin
         tick();
         chk("t2_release_valid", 32'(evt_valid), 0);
      end
      chk("t2_release_stable", 32'(stable), 0);

      // 3: short glitch filtered, long pulse gives one event
`ifdef BTN_ARB_DEBOUNCE_EN
      btn_raw[1] = 1'b1;
      tick(3);
      btn_raw[1] = 1'b0;
      for (int c = 0; c < 12; c++) begin
         tick();
         chk("t3_glitch_stable", 32'(stable), 0);
         chk("t3_glitch_valid", 32'(evt_valid), 0);
      end
`endif
      nev = 0;
      btn_raw[1] = 1'b1;
      for (int c = 0; c < 30; c++) begin
         if (c == 4) btn_raw[1] = 1'b0;
         tick();
         if (evt_valid) begin
            nev++;
            chk("t3_id", 32'(evt_id), 1);
         end
      end
      chk("t3_count", 32'(nev), 1);
      chk("t3_pending", 32'(pending), 0);

      // 4: simultaneous presses, round-robin order
      do_reset();
      btn_raw = 4'b1001;
      tick(LAT);
      chk("t4a_pending", 32'(pending), 4'b1001);
      chk("t4a_stable", 32'(stable), 4'b1001);
      tick();
      chk("t4a_valid0", 32'(evt_valid), 1);
      chk("t4a_id0", 32'(evt_id), 0);
      tick();
      chk("t4a_gap", 32'(evt_valid), 0);
      chk("t4a_pending_mid", 32'(pending), 4'b1000);
      tick();
      chk("t4a_valid1", 32'(evt_valid), 1);
      chk("t4a_id1", 32'(evt_id), 3);
      tick();
      chk("t4a_done", 32'(evt_valid), 0);
      chk("t4a_pending_done", 32'(pending), 0);
      btn_raw = '0;
      for (int c = 0; c < LAT + 2; c++) begin
         tick();
         chk("t4a_release_valid", 32'(evt_valid), 0);
      end
      chk("t4a_release_stable", 32'(stable), 0);
      btn_raw = 4'b1010;
      tick(LAT);
      chk("t4b_pending", 32'(pending), 4'b1010);
      tick();
      chk("t4b_valid0", 32'(evt_valid), 1);
      chk("t4b_id0", 32'(evt_id), 1);
      tick();
      chk("t4b_gap", 32'(evt_valid), 0);
      tick();
      chk("t4b_valid1", 32'(evt_valid), 1);
      chk("t4b_id1", 32'(evt_id), 3);
      tick();
      chk("t4b_done", 32'(evt_valid), 0);
      chk("t4b_pending_done", 32'(pending), 0);
      btn_raw = '0;
      for (int c = 0; c < LAT + 2; c++) begin
         tick();
         chk("t4b_release_valid", 32'(evt_valid), 0);
      end

      // 5: stall with re-press landing on the accept edge
      evt_ready = 1'b0;
      btn_raw[2] = 1'b1;
      tick(LAT + 1);
      chk("t5_valid", 32'(evt_valid), 1);
      chk("t5_id", 32'(evt_id), 2);
      btn_raw[2] = 1'b0;
      for (int c = 1; c < 2 * LAT + GAP; c++) begin
         if (c - 1 == LAT + GAP) btn_raw[2] = 1'b1;
         tick();
         chk("t5_hold_valid", 32'(evt_valid), 1);
         chk("t5_hold_id", 32'(evt_id), 2);
         chk("t5_hold_pending", 32'(pending), 4'b0100);
      end
      evt_ready = 1'b1;
      tick();
      chk("t5_accept_valid", 32'(evt_valid), 0);
      chk("t5_accept_pending", 32'(pending), 4'b0100);
      chk("t5_accept_stable", 32'(stable), 4'b0100);
      tick();
      chk("t5_again_valid", 32'(evt_valid), 1);
      chk("t5_again_id", 32'(evt_id), 2);
      tick();
      chk("t5_again_done", 32'(evt_valid), 0);
      chk("t5_again_pending", 32'(pending), 0);
      for (int c = 0; c < 6; c++) begin
         tick();
         chk("t5_quiet_valid", 32'(evt_valid), 0);
      end

      // 5b: reset while an event is offered
      evt_ready = 1'b0;
      btn_raw[1] = 1'b1;
      tick(LAT + 1);
      chk("t5r_valid", 32'(evt_valid), 1);
      chk("t5r_id", 32'(evt_id), 1);
      tick(2);
      #2;
      nrst = 1'b0;
      #1;
      chk("t5r_valid_rst", 32'(evt_valid), 0);
      chk("t5r_pending_rst", 32'(pending), 0);
      chk("t5r_stable_rst", 32'(stable), 0);
      chk("t5r_id_rst", 32'(evt_id), 0);
      btn_raw = '0;
      tick();
      nrst = 1'b1;
      tick();

`ifndef BTN_ARB_DEBOUNCE_EN
      // 6: no debounce, channel 3
      evt_ready = 1'b1;
      btn_raw[3] = 1'b1;
      tick(2);
      chk("t6_stable_pre", 32'(stable), 0);
      tick();
      chk("t6_stable", 32'(stable), 4'b1000);
      chk("t6_pending", 32'(pending), 4'b1000);
      tick();
      chk("t6_valid", 32'(evt_valid), 1);
      chk("t6_id", 32'(evt_id), 3);
      tick();
      chk("t6_done", 32'(evt_valid), 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
